// File: rtl/axis_oversampler.sv
// Transmit-side 1-bit AXI-Stream oversampler: each accepted symbol (data + last)
// is re-emitted as OVERSAMPLE identical beats, honouring backpressure on both sides.
module axis_oversampler #(
  parameter int OVERSAMPLE = 4,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic s_axis_tdata,
  input  logic s_axis_tlast,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  output logic m_axis_tdata,
  output logic m_axis_tlast,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic o_busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             last_q, last_d;
  logic             beat_acc;
  logic             final_beat;
  logic             sym_acc;

  assign beat_acc   = (state_q == SEND) && m_axis_tready;
  assign final_beat = beat_acc && (cnt_q == CNT_LAST);

  // Refilling on the final replica keeps the output stream gap-free.
  assign s_axis_tready = !i_rst && ((state_q == IDLE) || final_beat);
  assign sym_acc       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    if (sym_acc) begin
      state_d = SEND;
      cnt_d   = '0;
      data_d  = s_axis_tdata;
      last_d  = s_axis_tlast;
    end else if (final_beat) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (beat_acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;
  assign o_busy        = (state_q == SEND);

endmodule

// File: tb/tb_axis_oversampler.sv
// Bench for axis_oversampler: three instances (OVERSAMPLE 4, 2, 16) checked against
// a replicate-and-vote reference model with randomized symbols and backpressure.
module tb_axis_oversampler;

  function automatic int os_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 2 : 16);
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] s_tdata  = 3'b001;
  logic [2:0] s_tlast  = 3'b000;
  logic [2:0] s_tvalid = 3'b001;
  logic [2:0] s_tready;
  logic [2:0] m_tdata;
  logic [2:0] m_tlast;
  logic [2:0] m_tvalid;
  logic [2:0] m_tready = 3'b111;
  logic [2:0] busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axis_oversampler #(.OVERSAMPLE(os_of(g))) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .s_axis_tdata (s_tdata[g]),
      .s_axis_tlast (s_tlast[g]),
      .s_axis_tvalid(s_tvalid[g]),
      .s_axis_tready(s_tready[g]),
      .m_axis_tdata (m_tdata[g]),
      .m_axis_tlast (m_tlast[g]),
      .m_axis_tvalid(m_tvalid[g]),
      .m_axis_tready(m_tready[g]),
      .o_busy       (busy[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance.
  logic [1:0] expq [3][$];
  logic [1:0] rxq  [3][$];
  int         beats [3];
  int         nlast [3];
  int         nacc  [3];
  int         run   [3];
  int         maxrun[3];
  int         acc_cyc[3];
  bit         prev_v [3];
  bit         held_v [3];
  logic [1:0] held_val[3];
  int         cyc = 0;

  initial begin
    for (int g = 0; g < 3; g++) begin
      beats[g] = 0; nlast[g] = 0; nacc[g] = 0; run[g] = 0; maxrun[g] = 0;
      acc_cyc[g] = 0; prev_v[g] = 0; held_v[g] = 0; held_val[g] = 2'b00;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        expq[g].delete();
        held_v[g] = 0;
        prev_v[g] = 0;
        run[g]    = 0;
      end else begin
        if (held_v[g]) begin
          check("hold_valid", {31'd0, m_tvalid[g]}, 32'd1);
          check("hold_data", {30'd0, m_tlast[g], m_tdata[g]}, {30'd0, held_val[g]});
        end
        if (m_tvalid[g] && !prev_v[g])
          check("latency", cyc, acc_cyc[g] + 1);
        if (m_tvalid[g]) begin
          run[g]++;
          if (run[g] > maxrun[g]) maxrun[g] = run[g];
        end else begin
          run[g] = 0;
        end
        if (s_tvalid[g] && s_tready[g]) begin
          for (int k = 0; k < os_of(g); k++) expq[g].push_back({s_tlast[g], s_tdata[g]});
          nacc[g]++;
          if (!busy[g]) acc_cyc[g] = cyc;
        end
        if (m_tvalid[g] && m_tready[g]) begin
          if (expq[g].size() == 0) begin
            check("extra_beat", 32'd1, 32'd0);
          end else begin
            check("beat", {30'd0, m_tlast[g], m_tdata[g]}, {30'd0, expq[g].pop_front()});
          end
          beats[g]++;
          if (m_tlast[g]) nlast[g]++;
          rxq[g].push_back({m_tlast[g], m_tdata[g]});
        end
        held_v[g]   = m_tvalid[g] && !m_tready[g];
        held_val[g] = {m_tlast[g], m_tdata[g]};
        prev_v[g]   = m_tvalid[g];
      end
    end
  end

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send_sym(input int g, input logic d, input logic l);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    s_tdata[g]  = d;
    s_tlast[g]  = l;
    s_tvalid[g] = 1'b1;
    do begin
      @(negedge clk);
      ok = s_tready[g];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, n < 3000}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input int g);
    beats[g] = 0; nlast[g] = 0; nacc[g] = 0; maxrun[g] = 0;
    rxq[g].delete();
  endtask

  logic [10:0] barker;
  bit          done;
  logic [1:0]  sent[$];

  initial begin
    barker = 11'b11100010010;
    done   = 0;

    // Reset: inputs asserted, outputs must stay quiet.
    repeat (5) begin
      @(negedge clk);
      check("rst_s_tready", {31'd0, s_tready[0]}, 32'd0);
      check("rst_m_tvalid", {31'd0, m_tvalid[0]}, 32'd0);
      check("rst_m_tlast", {31'd0, m_tlast[0]}, 32'd0);
      check("rst_busy", {31'd0, busy[0]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", {31'd0, s_tready[0]}, 32'd1);
    @(posedge clk);
    #1;
    s_tvalid[0] = 1'b0;
    wait_idle(0);
    check("single_beats", beats[0], 32'd4);
    check("single_run", maxrun[0], 32'd4);
    check("single_tvalid_low", {31'd0, m_tvalid[0]}, 32'd0);

    // Barker frame, back to back, on every instance.
    for (int g = 0; g < 3; g++) begin
      clear_stats(g);
      for (int i = 10; i >= 0; i--) send_sym(g, barker[i], i == 0);
      s_tvalid[g] = 1'b0;
      wait_idle(g);
      check($sformatf("barker%0d_acc", os_of(g)), nacc[g], 32'd11);
      check($sformatf("barker%0d_beats", os_of(g)), beats[g], 11 * os_of(g));
      check($sformatf("barker%0d_run", os_of(g)), maxrun[g], 11 * os_of(g));
      check($sformatf("barker%0d_nlast", os_of(g)), nlast[g], os_of(g));
    end

    // Random symbols with random downstream backpressure, recovered by majority vote.
    clear_stats(0);
    sent.delete();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic d, l;
          d = 1'($urandom);
          l = ($urandom_range(0, 3) == 0);
          sent.push_back({l, d});
          send_sym(0, d, l);
          s_tvalid[0] = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          m_tready[0] = ~m_tready[0];
          repeat ($urandom_range(1, 10)) @(posedge clk);
          #1;
        end
      end
    join
    m_tready[0] = 1'b1;
    wait_idle(0);
    check("rand_groups", rxq[0].size() / 4, sent.size());
    for (int i = 0; i < sent.size() && (i + 1) * 4 <= rxq[0].size(); i++) begin
      int od, ol;
      od = 0;
      ol = 0;
      for (int k = 0; k < 4; k++) begin
        od += rxq[0][i*4+k][0];
        ol += rxq[0][i*4+k][1];
      end
      check($sformatf("vote_sym%0d", i), {30'd0, ol > 2, od > 2}, {30'd0, sent[i]});
    end

    // Reset in the middle of a symbol after two replicas.
    clear_stats(0);
    send_sym(0, 1'b1, 1'b1);
    s_tvalid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_beats", beats[0], 32'd2);
    @(negedge clk);
    check("midrst_tvalid", {31'd0, m_tvalid[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy[0]}, 32'd0);
    @(posedge clk);
    #1;
    beats[0] = 0;
    send_sym(0, 1'b0, 1'b0);
    s_tvalid[0] = 1'b0;
    wait_idle(0);
    check("midrst_fresh_beats", beats[0], 32'd4);

    for (int g = 0; g < 3; g++)
      check($sformatf("queue_empty%0d", g), expq[g].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_oversampler.md
# axis_oversampler

Transmit-side counterpart of the 1-bit oversampling receive path. Accepts one 1-bit AXI-Stream symbol at a time and re-emits it as OVERSAMPLE identical consecutive output beats, so that a downstream majority-vote receiver recovers the original symbol and frame boundary. The block sits between the symbol/frame generator and the oversampled channel of the Barker correlator test chain. It fully honours backpressure on both sides.

## Interface

- OVERSAMPLE, 4, number of output beats per input symbol; legal range 2..16.
- CNT_W, $clog2(OVERSAMPLE), replica counter width; derived, do not override.

- i_clk  input  1  single clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  1  input symbol.
- s_axis_tlast  input  1  input end-of-frame marker.
- s_axis_tvalid  input  1  input symbol valid.
- s_axis_tready  output  1  block can accept a symbol this cycle.
- m_axis_tdata  output  1  oversampled symbol beat.
- m_axis_tlast  output  1  end-of-frame, replicated on every beat of the last symbol.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  downstream accepts the beat.
- o_busy  output  1  a symbol is held and has replicas not yet accepted.

## Operation

- Two states: IDLE (no symbol held) and SEND (symbol held, replica counter cnt in 0..OVERSAMPLE-1).
- IDLE: s_axis_tready=1, m_axis_tvalid=0. On s_axis_tvalid&&s_axis_tready, capture tdata/tlast into the hold register, cnt<=0, go to SEND.
- SEND: m_axis_tvalid=1, m_axis_tdata/tlast = held values. The values must not change while m_axis_tvalid=1 and m_axis_tready=0.
- Each accepted beat (m_axis_tvalid&&m_axis_tready) increments cnt.
- When the beat at cnt==OVERSAMPLE-1 is accepted, the symbol is complete:
  - If s_axis_tvalid is high in that same cycle, capture the new symbol, reset cnt to 0, and stay in SEND. There is no idle gap.
  - Otherwise go to IDLE.
- s_axis_tready = IDLE || (SEND && cnt==OVERSAMPLE-1 && m_axis_tready). This is the only combinational path from m_axis_tready to s_axis_tready; it is permitted.
- tlast is replicated on all OVERSAMPLE beats. This lets a majority-vote receiver recover it; a single-beat tlast would be voted away.
- o_busy = (state==SEND).
- A pending s_axis_tvalid does not disturb a symbol in progress. The input is simply stalled (s_axis_tready=0) until the final replica is accepted.
- cnt never exceeds OVERSAMPLE-1. No wrap beyond that value occurs.

## Timing

- Reset (i_rst=1 at a rising edge):
  - State goes to IDLE, cnt to 0, and the hold register to 0.
  - m_axis_tvalid, m_axis_tdata, m_axis_tlast and o_busy are all 0.
  - s_axis_tready is 0 while i_rst is high and 1 from the first cycle after i_rst falls.
- Reset during SEND discards the held symbol and its remaining replicas immediately. The next cycle shows m_axis_tvalid=0.
- Latency: a symbol accepted at edge k drives m_axis_tvalid=1 with its data in the cycle after edge k.
- Throughput with m_axis_tready held at 1: exactly one input symbol per OVERSAMPLE cycles, and m_axis_tvalid stays continuously 1 across back-to-back symbols.
- Under backpressure, each m_axis_tready=0 cycle during SEND delays completion by exactly one cycle.
- All outputs except s_axis_tready are registered.

## Test plan

- Reset check: hold i_rst for 5 cycles with s_axis_tvalid=1 and m_axis_tready=1 -> s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0 and o_busy=0 throughout; s_axis_tready=1 on the first cycle after release.
- Single symbol: OVERSAMPLE=4, send tdata=1, tlast=0, m_axis_tready=1 -> exactly 4 beats of tdata=1 starting 1 cycle after acceptance, then m_axis_tvalid=0.
- Back-to-back frame: send the 11-chip Barker sequence 1,1,1,0,0,0,1,0,0,1,0 with tlast on the final chip and s_axis_tvalid held high -> 44 contiguous valid beats; beats 41..44 have tlast=1, all earlier beats tlast=0; s_axis_tready pulses once every 4 cycles.
- Random backpressure: toggle m_axis_tready with random intervals of 1..10 cycles, and pass the output through the oversample receiver/majority-vote model -> the recovered tdata/tlast stream equals the input; output data never changes while tvalid=1 and tready=0.
- Reset mid-symbol: assert i_rst after 2 of 4 replicas have been accepted -> m_axis_tvalid=0 on the next cycle, and the next accepted symbol yields a fresh full 4 beats.
- Parameter sweep: OVERSAMPLE=2 and 16, using the Barker-frame scenario -> 22 and 176 beats respectively, with correct tlast placement.
